// File: rtl/nonce_collect_pkg.sv
// Shared types and constants for the nonce collector: word widths, output FSM
// states and a constant-foldable clog2.
package nonce_collect_pkg;

    localparam int NONCE_W = 32;
    localparam int DROP_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with registered write and first-word-fall-through read.
// DEPTH must be a power of two so the pointers wrap naturally.
module nonce_fifo
    import nonce_collect_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [clog2(DEPTH):0]    count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and count define content.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/nonce_collect.sv
// Collects golden-nonce pulses from SLAVES sources, arbitrates them round-robin
// into a FIFO and drains it through the serial send/busy handshake.
// Optional NONCE_DEDUP_EN discards a granted nonce equal to the last one queued.
//
// Handshake: serial_send is a one-cycle strobe with golden_nonce stable; the
// transmitter raises serial_busy while sending and drops it when finished. If
// busy never rises within BUSY_TIMEOUT cycles the same word is strobed again.
module nonce_collect
    import nonce_collect_pkg::*;
#(
    parameter int SLAVES       = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                        uart_clk,
    input  logic                        reset,
    input  logic [SLAVES-1:0]           new_nonces,
    input  logic [SLAVES*NONCE_W-1:0]   slave_nonces,
    output logic [NONCE_W-1:0]          golden_nonce,
    output logic                        serial_send,
    input  logic                        serial_busy,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                        overflow,
    output logic [DROP_W-1:0]           drop_count,
    output state_e                      fsm_state
);

    localparam int RR_W  = (SLAVES > 1) ? clog2(SLAVES) : 1;
    localparam int TMR_W = clog2(BUSY_TIMEOUT) + 1;

    logic [SLAVES-1:0]  pend_valid_q, pend_valid_d;
    logic [NONCE_W-1:0] pend_nonce_q [SLAVES];
    logic [NONCE_W-1:0] pend_nonce_d [SLAVES];
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               overflow_q, overflow_d;
    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [NONCE_W-1:0] golden_q, golden_d;

    logic               grant_found;
    logic [RR_W-1:0]    grant_idx;
    logic [RR_W-1:0]    grant_rr_next;
    logic [NONCE_W-1:0] grant_nonce;
    int                 best_dist;
    int                 drops;
    logic [31:0]        drop_sum;

    logic               fifo_wr;
    logic               fifo_rd;
    logic [NONCE_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;

    // Round-robin pick: the valid source closest at or after rr_q, wrapping.
    always_comb begin
        grant_found   = 1'b0;
        grant_idx     = '0;
        grant_rr_next = rr_q;
        grant_nonce   = '0;
        best_dist     = SLAVES;
        if (!fifo_full) begin
            for (int i = 0; i < SLAVES; i++) begin
                if (pend_valid_q[i] &&
                    (((i - int'(rr_q)) + SLAVES) % SLAVES) < best_dist) begin
                    best_dist     = ((i - int'(rr_q)) + SLAVES) % SLAVES;
                    grant_found   = 1'b1;
                    grant_idx     = RR_W'(i);
                    grant_rr_next = RR_W'((i + 1) % SLAVES);
                    grant_nonce   = pend_nonce_q[i];
                end
            end
        end
        rr_d = grant_found ? grant_rr_next : rr_q;
    end

`ifdef NONCE_DEDUP_EN
    logic [NONCE_W-1:0] last_q;
    logic               last_valid_q;

    assign fifo_wr = grant_found && !(last_valid_q && (grant_nonce == last_q));

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (fifo_wr) begin
            last_q       <= grant_nonce;
            last_valid_q <= 1'b1;
        end
    end
`else
    assign fifo_wr = grant_found;
`endif

    // A fresh pulse always wins; it only counts as a drop if the old value
    // was still pending and not taken by the arbiter this cycle.
    always_comb begin
        drops        = 0;
        pend_valid_d = pend_valid_q;
        for (int i = 0; i < SLAVES; i++) begin
            pend_nonce_d[i] = pend_nonce_q[i];
            if (new_nonces[i]) begin
                pend_nonce_d[i] = slave_nonces[i*NONCE_W +: NONCE_W];
                pend_valid_d[i] = 1'b1;
                if (pend_valid_q[i] && !(grant_found && (grant_idx == RR_W'(i)))) begin
                    drops = drops + 1;
                end
            end else if (grant_found && (grant_idx == RR_W'(i))) begin
                pend_valid_d[i] = 1'b0;
            end
        end
        drop_sum   = 32'(drop_q) + 32'(drops);
        drop_d     = (drop_sum > 32'h0000_FFFF) ? '1 : drop_sum[DROP_W-1:0];
        overflow_d = overflow_q || (drops != 0);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        golden_d    = golden_q;
        fifo_rd     = 1'b0;
        serial_send = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd  = 1'b1;
                    golden_d = fifo_rdata;
                    state_d  = SEND;
                end
            end
            SEND: begin
                serial_send = 1'b1;
                timer_d     = '0;
                state_d     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                timer_d = timer_q + 1'b1;
                if (serial_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = SEND;
                end
            end
            WAIT_DONE: begin
                if (!serial_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            pend_valid_q <= '0;
            for (int i = 0; i < SLAVES; i++) begin
                pend_nonce_q[i] <= '0;
            end
            rr_q       <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            golden_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            for (int i = 0; i < SLAVES; i++) begin
                pend_nonce_q[i] <= pend_nonce_d[i];
            end
            rr_q       <= rr_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            golden_q   <= golden_d;
        end
    end

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NONCE_W)
    ) u_fifo (
        .clk     (uart_clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (grant_nonce),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign golden_nonce = golden_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_q;
    assign fsm_state    = state_q;

endmodule

// File: doc/nonce_collect.md
Name: nonce_collect

Overview:
- Sits between the per-slave nonce sources (local hashcores after clock-domain sync, external slave receivers) and the serial transmitter.
- Latches every golden-nonce pulse from SLAVES sources and arbitrates round-robin into a FIFO.
- Drains the FIFO one word at a time through the transmitter's send/busy handshake, so simultaneous finds are never silently lost while the UART is busy.
- Runs entirely in the uart_clk domain.

Parameters:
- SLAVES, 2, number of nonce sources (1..8).
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.
- BUSY_TIMEOUT, 16, cycles to wait for serial_busy to rise after a send before re-issuing it.

Ports:
- uart_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- new_nonces  in  SLAVES  one-cycle pulse per source: nonce valid.
- slave_nonces  in  SLAVES*32  nonce of source i at [i*32+31:i*32].
- golden_nonce  out  32  word presented to the transmitter.
- serial_send  out  1  one-cycle send strobe to the transmitter.
- serial_busy  in  1  transmitter busy.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a pending nonce was overwritten.
- drop_count  out  16  saturating count of overwritten nonces.

Behaviour:
- Reset (synchronous, any state, including mid-transfer):
  - golden_nonce=0, serial_send=0, fifo_count=0, overflow=0, drop_count=0.
  - FIFO emptied, all pend_valid cleared, round-robin pointer=0, FSM=IDLE.
- Capture, per source i:
  - new_nonces[i]=1 loads pend_nonce[i] from slave_nonces and sets pend_valid[i].
  - If pend_valid[i] is already set and not granted this cycle, the old value is overwritten, drop_count increments (saturates at 16'hFFFF), and overflow is set.
  - If it is granted in the same cycle, the new pulse wins (valid stays 1, new value) with no drop.
- Arbiter:
  - Each cycle, if the FIFO is not full, grant the first valid source at or after the rr pointer (wrapping) and write its nonce.
  - Clear that source's pend_valid; rr pointer becomes grant+1 mod SLAVES.
  - At most one write per cycle.
  - FIFO full: no grant; pending values are held.
- FIFO:
  - Registered write, first-word-fall-through read.
  - Write and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count==FIFO_DEPTH means full.
- Output FSM:
  - IDLE: FIFO non-empty -> pop, golden_nonce<=head, go to SEND.
  - SEND: serial_send=1 for exactly one cycle; clear timer; go to WAIT_BUSY.
  - WAIT_BUSY: serial_busy=1 -> WAIT_DONE. Timer reaches BUSY_TIMEOUT-1 -> SEND (re-issue same word).
  - WAIT_DONE: serial_busy=0 -> IDLE.
  - golden_nonce is held stable from the pop until the next pop.
- Latency: pulse sampled at edge t, empty FIFO, FSM idle -> FIFO write at t+1, pop at t+2, serial_send high in the cycle after edge t+2.
- Ordering: with FIFO room, simultaneous pulses drain in round-robin order starting at the rr pointer.

Optional Feature:
- Macro NONCE_DEDUP_EN.
- Defined:
  - Keep a last-written nonce register plus a valid bit, both cleared on reset.
  - A granted nonce equal to the last written value is discarded: pend_valid cleared, no FIFO write, drop_count unchanged.
  - The last-written register updates only on an actual FIFO write.
- Undefined: every granted nonce is written; no compare logic.

Decomposition:
- Shared package:
  - NONCE_W=32.
  - FSM state type {IDLE, SEND, WAIT_BUSY, WAIT_DONE}.
  - clog2 function.
  - DROP_W=16.
- One sub-module, nonce_fifo: synchronous FIFO with parameters DEPTH and WIDTH; ports wr_en, wr_data, rd_en, rd_data, count, full, empty.
- Capture, arbiter and FSM stay in nonce_collect.

Test Plan:
- Single nonce: pulse source 0 with 32'hDEADBEEF while serial_busy=0, busy modelled as rising 1 cycle after send for 10 cycles -> serial_send pulses once 3 cycles later, golden_nonce=32'hDEADBEEF, fifo_count returns to 0.
- Simultaneous: pulse both sources together (A0000001, B0000002), rr=0 -> transmitted in order A0000001 then B0000002, two send strobes, no drop.
- Overwrite: hold FIFO full (FIFO_DEPTH=8, busy stuck high), pulse source 1 twice -> drop_count=1, overflow=1, and the second value is transmitted after busy releases.
- Busy timeout: serial_busy never rises -> serial_send re-pulses every 17 cycles with the same golden_nonce; raising busy stops the retries.
- Reset mid-transfer: assert reset in WAIT_DONE with 3 entries queued -> next cycle fifo_count=0, serial_send=0, golden_nonce=0; nothing further sent.
- NONCE_DEDUP_EN: same nonce 32'h12345678 pulsed twice, 5 cycles apart -> exactly one send; without the macro -> two sends.
